player_hit_detector: RTL



---
 rtl/game_pkg.sv | 27 ++
 rtl/player_hit_detector_if.sv | 33 +++
 rtl/rect_overlap.sv | 60 ++++++
 rtl/player_hit_detector.sv | 125 ++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared game constants, sprite sizes and hit-FSM encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    localparam int SCREEN_W   = 1024;
    localparam int SCREEN_H   = 768;
    localparam int COORD_W    = 12;

    localparam int MISSILE_W  = 4;
    localparam int MISSILE_H  = 16;
    localparam int PLAYER_W   = 48;
    localparam int PLAYER_H   = 64;

    localparam int LIVES_INIT = 3;

    typedef enum logic [1:0] {
        ARMED  = 2'b00,
        INVULN = 2'b01,
        DEAD   = 2'b10
    } hit_state_t;

endpackage
`default_nettype wire

// File: rtl/player_hit_detector_if.sv
`default_nettype none
// ============================================================================
//  Module      : player_hit_detector_if
//  Description : Missile/player geometry inputs and hit/lives status outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface player_hit_detector_if;
    import game_pkg::*;

    logic [COORD_W-1:0] missile_x;
    logic [COORD_W-1:0] missile_y;
    logic               missile_on;
    logic [COORD_W-1:0] player_x;
    logic [COORD_W-1:0] player_y;
    logic               new_game;
    logic               hit_pulse;
    logic               missile_kill;
    logic [1:0]         lives_out;
    logic               invuln_out;
    logic               game_over;

    modport master (
        output missile_x, missile_y, missile_on, player_x, player_y, new_game,
        input  hit_pulse, missile_kill, lives_out, invuln_out, game_over
    );

    modport slave (
        input  missile_x, missile_y, missile_on, player_x, player_y, new_game,
        output hit_pulse, missile_kill, lives_out, invuln_out, game_over
    );

endinterface
`default_nettype wire

// File: rtl/rect_overlap.sv
`default_nettype none
// ============================================================================
//  Module      : rect_overlap
//  Description : Registered strict AABB overlap test between rectangles A and B.
//  Revision    : 1.0 - initial release
// ============================================================================
module rect_overlap
    import game_pkg::*;
#(
    parameter int A_W = 4,
    parameter int A_H = 16,
    parameter int B_W = 48,
    parameter int B_H = 64
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic [COORD_W-1:0] a_x,
    input  logic [COORD_W-1:0] a_y,
    input  logic               a_on,
    input  logic [COORD_W-1:0] b_x,
    input  logic [COORD_W-1:0] b_y,
    output logic               overlap
);

    // One extra bit so right/bottom edges near the coordinate limit never wrap
    localparam logic [COORD_W:0] c_A_W = A_W[COORD_W:0];
    localparam logic [COORD_W:0] c_A_H = A_H[COORD_W:0];
    localparam logic [COORD_W:0] c_B_W = B_W[COORD_W:0];
    localparam logic [COORD_W:0] c_B_H = B_H[COORD_W:0];

    logic [COORD_W:0] w_ax, w_ay, w_bx, w_by;
    logic [COORD_W:0] w_ax_end, w_ay_end, w_bx_end, w_by_end;
    logic             w_overlap;
    logic             r_overlap;

    assign w_ax     = {1'b0, a_x};
    assign w_ay     = {1'b0, a_y};
    assign w_bx     = {1'b0, b_x};
    assign w_by     = {1'b0, b_y};
    assign w_ax_end = w_ax + c_A_W;
    assign w_ay_end = w_ay + c_A_H;
    assign w_bx_end = w_bx + c_B_W;
    assign w_by_end = w_by + c_B_H;

    assign w_overlap = a_on
                    && (w_ax < w_bx_end) && (w_bx < w_ax_end)
                    && (w_ay < w_by_end) && (w_by < w_ay_end);

    always_ff @(posedge pclk) begin
        if (!rst) begin
            r_overlap <= 1'b0;
        end else begin
            r_overlap <= w_overlap;
        end
    end

    assign overlap = r_overlap;

endmodule
`default_nettype wire

// File: rtl/player_hit_detector.sv
`default_nettype none
// ============================================================================
//  Module      : player_hit_detector
//  Description : Missile-vs-player hit detection, lives, invulnerability window.
//  Revision    : 1.0 - initial release
// ============================================================================
module player_hit_detector
    import game_pkg::*;
#(
    parameter int MISSILE_W     = game_pkg::MISSILE_W,
    parameter int MISSILE_H     = game_pkg::MISSILE_H,
    parameter int PLAYER_W      = game_pkg::PLAYER_W,
    parameter int PLAYER_H      = game_pkg::PLAYER_H,
    parameter int LIVES_INIT    = game_pkg::LIVES_INIT,
    parameter int INVULN_CYCLES = 6500000
) (
    input  logic                 pclk,
    input  logic                 rst,
    player_hit_detector_if.slave bus
);

    localparam int                c_CNT_W    = $clog2(INVULN_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(INVULN_CYCLES - 1);
    localparam logic [1:0]        c_LIVES    = LIVES_INIT[1:0];

    logic               w_overlap;
    hit_state_t         r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]         r_lives, w_lives_nxt;
    logic               r_hit, w_hit_nxt;
    logic               r_invuln, w_invuln_nxt;
    logic               r_game_over, w_game_over_nxt;

    rect_overlap #(
        .A_W (MISSILE_W),
        .A_H (MISSILE_H),
        .B_W (PLAYER_W),
        .B_H (PLAYER_H)
    ) u_rect_overlap (
        .pclk    (pclk),
        .rst     (rst),
        .a_x     (bus.missile_x),
        .a_y     (bus.missile_y),
        .a_on    (bus.missile_on),
        .b_x     (bus.player_x),
        .b_y     (bus.player_y),
        .overlap (w_overlap)
    );

    always_ff @(posedge pclk) begin
        if (!rst) begin
            r_state     <= ARMED;
            r_cnt       <= '0;
            r_lives     <= c_LIVES;
            r_hit       <= 1'b0;
            r_invuln    <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_lives     <= w_lives_nxt;
            r_hit       <= w_hit_nxt;
            r_invuln    <= w_invuln_nxt;
            r_game_over <= w_game_over_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_lives_nxt     = r_lives;
        w_hit_nxt       = 1'b0;
        w_invuln_nxt    = r_invuln;
        w_game_over_nxt = r_game_over;

        // new_game overrides any overlap pending in the same cycle
        if (bus.new_game) begin
            w_state_nxt     = ARMED;
            w_cnt_nxt       = '0;
            w_lives_nxt     = c_LIVES;
            w_invuln_nxt    = 1'b0;
            w_game_over_nxt = 1'b0;
        end else begin
            case (r_state)
                ARMED: begin
                    if (w_overlap) begin
                        w_hit_nxt = 1'b1;
                        if (r_lives > 2'd1) begin
                            w_lives_nxt  = r_lives - 2'd1;
                            w_cnt_nxt    = c_CNT_LOAD;
                            w_state_nxt  = INVULN;
                            w_invuln_nxt = 1'b1;
                        end else begin
                            w_lives_nxt     = 2'd0;
                            w_state_nxt     = DEAD;
                            w_game_over_nxt = 1'b1;
                        end
                    end
                end
                INVULN: begin
                    if (r_cnt == '0) begin
                        w_state_nxt  = ARMED;
                        w_invuln_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end
                DEAD: begin
                    w_state_nxt = DEAD;
                end
                default: begin
                    w_state_nxt = ARMED;
                end
            endcase
        end
    end

    assign bus.hit_pulse    = r_hit;
    assign bus.missile_kill = r_hit;
    assign bus.lives_out    = r_lives;
    assign bus.invuln_out   = r_invuln;
    assign bus.game_over    = r_game_over;

endmodule
`default_nettype wire
